// File: rtl/mcpu_gen.sv
// mcpu_gen -- parametrised accumulator CPU, next generation of the minimal
// 8-bit core. It runs from one shared memory over a req/ready bus and
// tolerates any number of wait states.
//
// The instruction word is {op[1:0], operand[AW-1:0]}, where AW = DW-2.
//   00 NOR  acc <= ~(acc | mem[operand])
//   01 ADD  {carry,acc} <= acc + mem[operand]
//   10 STA  mem[operand] <= acc
//   11 JCC  if carry: clear carry and fall through
//           else: jump to operand (a jump to itself halts)
//
// Optional feature: define MCPU_GEN_ADC_EN to turn ADD into add-with-carry.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   mem_req    out  bus request (low while halted or in reset)
//   mem_we     out  1 = write (STA execute), 0 = read
//   mem_addr   out  AW-bit bus address
//   mem_wdata  out  write data (acc during STA, else 0)
//   mem_rdata  in   read data, sampled only on a completing read
//   mem_ready  in   slave ready; a transfer completes on mem_req & mem_ready
//   acc_out    out  accumulator
//   carry_out  out  carry flag
//   retire     out  one-cycle pulse per completed instruction
//   halted     out  core stopped on a jump-to-self
module mcpu_gen #(
    parameter int unsigned DW       = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-3:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [DW-1:0] acc_out,
    output logic          carry_out,
    output logic          retire,
    output logic          halted
);

    localparam int unsigned   AW     = DW - 2;
    localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_ADD = 2'b01,
        OP_STA = 2'b10,
        OP_JCC = 2'b11
    } op_t;

    state_t        state;
    op_t           op;
    logic [AW-1:0] opnd;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic          carry;
    logic [DW:0]   sum;

    logic [1:0]    fetch_op;
    logic [AW-1:0] fetch_opnd;

    assign fetch_op   = mem_rdata[DW-1:DW-2];
    assign fetch_opnd = mem_rdata[AW-1:0];

    always_comb begin
        sum = {1'b0, acc} + {1'b0, mem_rdata};
`ifdef MCPU_GEN_ADC_EN
        sum = sum + {{DW{1'b0}}, carry};
`else
        sum = sum + '0;
`endif
    end

    // Bus signals are decoded from registered state; gating with rst makes
    // them drop in the same cycle reset rises, aborting any transfer.
    assign mem_req   = ~rst & (state != HALT);
    assign mem_addr  = rst ? '0 : ((state == EXEC) ? opnd : pc);
    assign mem_we    = ~rst & (state == EXEC) & (op == OP_STA);
    assign mem_wdata = mem_we ? acc : '0;

    assign acc_out   = acc;
    assign carry_out = carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            op     <= OP_NOR;
            opnd   <= '0;
            pc     <= RST_PC;
            acc    <= '0;
            carry  <= 1'b0;
            retire <= 1'b0;
            halted <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        if (fetch_op != OP_JCC) begin
                            op    <= op_t'(fetch_op);
                            opnd  <= fetch_opnd;
                            pc    <= pc + 1'b1;
                            state <= EXEC;
                        end else if (carry) begin
                            carry  <= 1'b0;
                            pc     <= pc + 1'b1;
                            retire <= 1'b1;
                        end else if (fetch_opnd != pc) begin
                            pc     <= fetch_opnd;
                            retire <= 1'b1;
                        end else begin
                            retire <= 1'b1;
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    end
                end
                EXEC: begin
                    if (mem_ready) begin
                        case (op)
                            OP_NOR: acc <= ~(acc | mem_rdata);
                            OP_ADD: {carry, acc} <= sum;
                            default: ;
                        endcase
                        retire <= 1'b1;
                        state  <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
